// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Ports: clk, rst (async, active-high); id_* decode bundle in; flush in;
//   stall out (combinational); ID_EX_* registered bundle out.
//   Optional HAZARD_STATS_EN adds saturating stall_cnt / flush_cnt outputs.
module id_ex_stage_reg #(
  parameter int DATA_W  = 16,
  parameter int REG_W   = 4,
  parameter int ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [REG_W-1:0]   id_op1,
  input  logic [REG_W-1:0]   id_op2,
  input  logic [1:0]         id_src_en,
  input  logic [DATA_W-1:0]  id_rd1,
  input  logic [DATA_W-1:0]  id_rd2,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic               id_regWrite,
  input  logic               id_memRead,
  input  logic               id_memWrite,
  input  logic               id_aluSrc,
  input  logic [ALUOP_W-1:0] id_aluOp,
  input  logic               flush,
  output logic               stall,
  output logic               ID_EX_valid,
  output logic [REG_W-1:0]   ID_EX_op1,
  output logic [REG_W-1:0]   ID_EX_op2,
  output logic [DATA_W-1:0]  ID_EX_rd1,
  output logic [DATA_W-1:0]  ID_EX_rd2,
  output logic [DATA_W-1:0]  ID_EX_imm,
  output logic               ID_EX_regWrite,
  output logic               ID_EX_memRead,
  output logic               ID_EX_memWrite,
  output logic               ID_EX_aluSrc,
  output logic [ALUOP_W-1:0] ID_EX_aluOp
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]        stall_cnt,
  output logic [15:0]        flush_cnt
`endif
);

  logic hit1;
  logic hit2;
  logic hazard;
  logic bubble;
  logic take;

  // A load in EX whose destination a decode source needs next cycle.
  assign hit1   = id_src_en[0] & (id_op1 == ID_EX_op1);
  assign hit2   = id_src_en[1] & (id_op2 == ID_EX_op1);
  assign hazard = ID_EX_valid & ID_EX_memRead
                & (ID_EX_op1 != '0) & id_valid
                & (hit1 | hit2);

  // Flush kills the decode instruction anyway, so no stall is needed.
  assign stall  = hazard & ~flush;
  assign bubble = flush | stall;
  assign take   = ~bubble & id_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ID_EX_valid    <= 1'b0;
      ID_EX_op1      <= '0;
      ID_EX_op2      <= '0;
      ID_EX_rd1      <= '0;
      ID_EX_rd2      <= '0;
      ID_EX_imm      <= '0;
      ID_EX_regWrite <= 1'b0;
      ID_EX_memRead  <= 1'b0;
      ID_EX_memWrite <= 1'b0;
      ID_EX_aluSrc   <= 1'b0;
      ID_EX_aluOp    <= '0;
    end else begin
      // Operand fields always follow decode; only valid/control gate.
      ID_EX_op1      <= id_op1;
      ID_EX_op2      <= id_op2;
      ID_EX_rd1      <= id_rd1;
      ID_EX_rd2      <= id_rd2;
      ID_EX_imm      <= id_imm;
      ID_EX_valid    <= take;
      ID_EX_regWrite <= take & id_regWrite;
      ID_EX_memRead  <= take & id_memRead;
      ID_EX_memWrite <= take & id_memWrite;
      ID_EX_aluSrc   <= take & id_aluSrc;
      ID_EX_aluOp    <= take ? id_aluOp : '0;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      if (flush && flush_cnt != 16'hFFFF)
        flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule
